// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, STATUS/CTRL bit positions, FSM states.
// Optional 8E1 framing is enabled by defining UART_PARITY_EN.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SUB_W      = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned IDX_W      = 3;

    // Register offsets from BASE_ADDR
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    // STATUS bit positions
    localparam int unsigned ST_TX_FULL   = 0;
    localparam int unsigned ST_TX_EMPTY  = 1;
    localparam int unsigned ST_RX_EMPTY  = 2;
    localparam int unsigned ST_RX_FULL   = 3;
    localparam int unsigned ST_OVERRUN   = 4;
    localparam int unsigned ST_FRAME_ERR = 5;
    localparam int unsigned ST_TX_BUSY   = 6;
    localparam int unsigned ST_PAR_ERR   = 7;

    // CTRL bit positions
    localparam int unsigned CTRL_TX_EN = 0;
    localparam int unsigned CTRL_RX_EN = 1;
    localparam int unsigned CTRL_CLR   = 7;

    // Oversample tick indices: last tick of a bit, and the mid-bit tick of the start bit
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module uart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full_c,
    output logic             empty_c,
    output logic [WIDTH-1:0] head_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop_c;
    logic             do_push_c;

    assign empty_c   = (wr_ptr == rd_ptr);
    assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_c    = mem[rd_ptr[AW-1:0]];
    assign do_pop_c  = pop && !empty_c;
    assign do_push_c = push && (!full_c || do_pop_c);

    // Pointer update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_top.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs on the TRSQ8 peripheral bus.
// Define UART_PARITY_EN for 8E1 framing with a sticky parity-error flag.
module uart_top
    import uart_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR   = 8'h88,
    parameter logic [7:0]  LAST_ADDR   = 8'h8B,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [7:0]  DEFAULT_DIV = 8'd53
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       wr_en,
    input  logic       rd_en,
    output logic       tx,
    input  logic       rx
);

    // Bus decode
    logic       sel_c;
    logic [1:0] off_c;
    logic       wr_data_c, wr_ctrl_c, wr_div_c, rx_pop_c;
    logic [7:0] rdata_c;
    logic [7:0] status_c;

    // Control / status registers
    logic       tx_en, rx_en;
    logic [7:0] div_q;
    logic [7:0] tick_cnt;
    logic       tick_c;
    logic       overrun_q, frame_err_q;

    // FIFO interfaces
    logic              tx_full_c, tx_empty_c, tx_pop_c;
    logic [DATA_W-1:0] tx_head_c;
    logic              rx_full_c, rx_empty_c, rx_push_c;
    logic [DATA_W-1:0] rx_head_c;

    // TX path
    uart_state_e       tx_state;
    logic [SUB_W-1:0]  tx_sub;
    logic [IDX_W-1:0]  tx_idx;
    logic [DATA_W-1:0] tx_shreg;
    logic              tx_bit_end_c;

    // RX path
    uart_state_e       rx_state;
    logic [SUB_W-1:0]  rx_sub;
    logic [IDX_W-1:0]  rx_idx;
    logic [DATA_W-1:0] rx_shreg;
    logic              rx_s1, rx_s2, rx_prev;
    logic              rx_fall_c, rx_sample_c, rx_frame_err_c, rx_overrun_c;

`ifdef UART_PARITY_EN
    logic tx_par;
    logic par_err_q;
    logic rx_par_err_c;
`endif

    assign sel_c     = (addr >= BASE_ADDR) && (addr <= LAST_ADDR);
    assign off_c     = 2'(addr - BASE_ADDR);
    assign wr_data_c = wr_en && sel_c && (off_c == REG_DATA);
    assign wr_ctrl_c = wr_en && sel_c && (off_c == REG_CTRL);
    assign wr_div_c  = wr_en && sel_c && (off_c == REG_DIV);
    assign rx_pop_c  = rd_en && sel_c && (off_c == REG_DATA);

    // STATUS assembly
    always_comb begin
        status_c               = '0;
        status_c[ST_TX_FULL]   = tx_full_c;
        status_c[ST_TX_EMPTY]  = tx_empty_c;
        status_c[ST_RX_EMPTY]  = rx_empty_c;
        status_c[ST_RX_FULL]   = rx_full_c;
        status_c[ST_OVERRUN]   = overrun_q;
        status_c[ST_FRAME_ERR] = frame_err_q;
        status_c[ST_TX_BUSY]   = (tx_state != S_IDLE);
`ifdef UART_PARITY_EN
        status_c[ST_PAR_ERR]   = par_err_q;
`endif
    end

    // Read mux; an empty RX FIFO reads as zero
    always_comb begin
        rdata_c = '0;
        case (off_c)
            REG_DATA:   rdata_c = rx_empty_c ? 8'h00 : rx_head_c;
            REG_STATUS: rdata_c = status_c;
            REG_CTRL:   rdata_c = {6'b0, rx_en, tx_en};
            REG_DIV:    rdata_c = div_q;
            default:    rdata_c = '0;
        endcase
    end

    assign dout = (sel_c && rd_en) ? rdata_c : 8'hzz;

    // Oversample tick generator; a DIV write restarts the count
    assign tick_c = (tick_cnt == div_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= DEFAULT_DIV;
            tick_cnt <= '0;
        end else if (wr_div_c) begin
            div_q    <= din;
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 8'd1;
        end
    end

    // CTRL enables and sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_en       <= 1'b0;
            rx_en       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            if (wr_ctrl_c) begin
                tx_en <= din[CTRL_TX_EN];
                rx_en <= din[CTRL_RX_EN];
            end
            if (wr_ctrl_c && din[CTRL_CLR]) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
                par_err_q   <= 1'b0;
`endif
            end
            if (rx_overrun_c)   overrun_q   <= 1'b1;
            if (rx_frame_err_c) frame_err_q <= 1'b1;
`ifdef UART_PARITY_EN
            if (rx_par_err_c)   par_err_q   <= 1'b1;
`endif
        end
    end

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_data_c),
        .wdata   (din),
        .pop     (tx_pop_c),
        .full_c  (tx_full_c),
        .empty_c (tx_empty_c),
        .head_c  (tx_head_c)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push_c),
        .wdata   (rx_shreg),
        .pop     (rx_pop_c),
        .full_c  (rx_full_c),
        .empty_c (rx_empty_c),
        .head_c  (rx_head_c)
    );

    // A new frame loads from IDLE, or straight out of the last stop tick so frames abut
    assign tx_bit_end_c = tick_c && (tx_sub == SUB_LAST);
    assign tx_pop_c     = tx_en && !tx_empty_c &&
                          ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_bit_end_c));

    // TX FSM: 16 ticks per state, LSB first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= S_IDLE;
            tx       <= 1'b1;
            tx_sub   <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else if (tx_pop_c) begin
            tx_state <= S_START;
            tx       <= 1'b0;
            tx_sub   <= '0;
            tx_shreg <= tx_head_c;
`ifdef UART_PARITY_EN
            tx_par   <= even_parity(tx_head_c);
`endif
        end else if (tx_state != S_IDLE) begin
            if (tick_c) tx_sub <= tx_sub + SUB_W'(1);
            if (tx_bit_end_c) begin
                case (tx_state)
                    S_START: begin
                        tx_state <= S_DATA;
                        tx       <= tx_shreg[0];
                        tx_idx   <= '0;
                    end
                    S_DATA: begin
                        tx_shreg <= tx_shreg >> 1;
                        tx_idx   <= tx_idx + IDX_W'(1);
                        if (tx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            tx_state <= S_PARITY;
                            tx       <= tx_par;
`else
                            tx_state <= S_STOP;
                            tx       <= 1'b1;
`endif
                        end else begin
                            tx <= tx_shreg[1];
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PARITY: begin
                        tx_state <= S_STOP;
                        tx       <= 1'b1;
                    end
`endif
                    default: begin
                        tx_state <= S_IDLE;
                        tx       <= 1'b1;
                    end
                endcase
            end
        end
    end

    // RX synchronizer plus previous-sample register for falling-edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall_c      = rx_prev && !rx_s2;
    assign rx_sample_c    = tick_c && (rx_sub == ((rx_state == S_START) ? SUB_MID : SUB_LAST));
    assign rx_push_c      = (rx_state == S_STOP) && rx_sample_c && rx_s2;
    assign rx_frame_err_c = (rx_state == S_STOP) && rx_sample_c && !rx_s2;
    assign rx_overrun_c   = rx_push_c && rx_full_c && !rx_pop_c;
`ifdef UART_PARITY_EN
    assign rx_par_err_c   = (rx_state == S_PARITY) && rx_sample_c &&
                            (rx_s2 != even_parity(rx_shreg));
`endif

    // RX FSM: start bit checked at mid-bit, then every 16 ticks lands mid-bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= S_IDLE;
            rx_sub   <= '0;
            rx_idx   <= '0;
            rx_shreg <= '0;
        end else if (rx_state == S_IDLE) begin
            if (rx_en && rx_fall_c) begin
                rx_state <= S_START;
                rx_sub   <= '0;
            end
        end else begin
            if (tick_c) rx_sub <= rx_sub + SUB_W'(1);
            if (rx_sample_c) begin
                case (rx_state)
                    S_START: begin
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                        rx_sub   <= '0;
                        rx_idx   <= '0;
                    end
                    S_DATA: begin
                        rx_shreg <= {rx_s2, rx_shreg[DATA_W-1:1]};
                        rx_idx   <= rx_idx + IDX_W'(1);
                        if (rx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state <= S_PARITY;
`else
                            rx_state <= S_STOP;
`endif
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PARITY: rx_state <= S_STOP;
`endif
                    default:  rx_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top (default 8N1 build), DIV=0 so one bit = 16 clocks.
module tb_uart_top;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] din = 8'h00;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       rx = 1'b1;
    logic       tx;
    // Released shared bus floats to all-ones through the pull-up
    tri1  [7:0] dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_top dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .tx      (tx),
        .rx      (rx)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        din   = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        addr  = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr  = a;
        rd_en = 1'b1;
        #1 d  = dout;
        @(negedge clk);
        rd_en = 1'b0;
        addr  = 8'h00;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    // Check first and last clock of every bit of one 8N1 frame starting at the next edge
    task automatic expect_frame(input logic [7:0] data);
        logic exp_bit;
        for (int c = 0; c < 160; c++) begin
            @(posedge clk);
            #1;
            if (c < 16)       exp_bit = 1'b0;
            else if (c < 144) exp_bit = data[(c - 16) / 16];
            else              exp_bit = 1'b1;
            if ((c % 16 == 0) || (c % 16 == 15))
                check($sformatf("tx_%02h_c%0d", data, c), {7'b0, tx}, {7'b0, exp_bit});
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop_bit;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic seen_low;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {7'b0, tx}, 8'h01);
        check("rst_dout_z", dout, 8'hFF);
        reset_n = 1'b1;
        read_check("rst_status", 8'h89, 8'h06);
        read_check("rst_ctrl",   8'h8A, 8'h00);
        read_check("rst_div",    8'h8B, 8'h35);

        // Decode boundaries: unselected or no strobe leaves the bus released
        @(negedge clk);
        addr = 8'h87; rd_en = 1'b1;
        #1 check("dout_below", dout, 8'hFF);
        addr = 8'h8C;
        #1 check("dout_above", dout, 8'hFF);
        addr = 8'h89; rd_en = 1'b0;
        #1 check("dout_no_rd", dout, 8'hFF);
        addr = 8'h00;

        // Single TX frame
        bus_write(8'h8B, 8'h00);
        read_check("div_zero", 8'h8B, 8'h00);
        bus_write(8'h8A, 8'h01);
        bus_write(8'h88, 8'hA5);
        expect_frame(8'hA5);
        addr = 8'h89; rd_en = 1'b1;
        #1 check("busy_in_stop", dout, 8'h46);
        rd_en = 1'b0; addr = 8'h00;
        @(posedge clk); #1;
        check("tx_idle_after", {7'b0, tx}, 8'h01);
        read_check("status_after_tx", 8'h89, 8'h06);

        // TX FIFO fill, overflow drop, back-to-back drain
        bus_write(8'h8A, 8'h00);
        bus_write(8'h88, 8'h11);
        bus_write(8'h88, 8'h22);
        bus_write(8'h88, 8'h33);
        bus_write(8'h88, 8'h44);
        read_check("tx_full", 8'h89, 8'h05);
        bus_write(8'h88, 8'h55);
        bus_write(8'h8A, 8'h01);
        expect_frame(8'h11);
        expect_frame(8'h22);
        expect_frame(8'h33);
        expect_frame(8'h44);
        seen_low = 1'b0;
        repeat (24) begin
            @(posedge clk); #1;
            if (tx == 1'b0) seen_low = 1'b1;
        end
        check("no_5th_frame", {7'b0, seen_low}, 8'h00);
        read_check("status_drained", 8'h89, 8'h06);

        // RX single byte, then a framing error and its clear
        bus_write(8'h8A, 8'h02);
        drive_rx(8'h3C, 1'b1);
        read_check("rx_not_empty", 8'h89, 8'h02);
        read_check("rx_data_3c",   8'h88, 8'h3C);
        read_check("rx_empty",     8'h89, 8'h06);
        drive_rx(8'h5A, 1'b0);
        read_check("frame_err", 8'h89, 8'h26);
        bus_write(8'h8A, 8'h83);
        read_check("frame_err_clr", 8'h89, 8'h06);
        read_check("ctrl_readback", 8'h8A, 8'h03);

        // RX overrun: fifth byte dropped, first four kept in order
        for (int i = 1; i <= 5; i++) drive_rx(8'(i), 1'b1);
        read_check("rx_full_ovr", 8'h89, 8'h1A);
        for (int i = 1; i <= 4; i++) read_check($sformatf("rx_order_%0d", i), 8'h88, 8'(i));
        read_check("ovr_sticky",  8'h89, 8'h16);
        read_check("rx_pop_empty", 8'h88, 8'h00);
        bus_write(8'h8A, 8'h83);
        read_check("ovr_clr", 8'h89, 8'h06);

        // Short low glitch is rejected, receiver recovers for the next frame
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        read_check("glitch_ignored", 8'h89, 8'h06);
        drive_rx(8'hC3, 1'b1);
        read_check("rx_after_glitch", 8'h88, 8'hC3);

        // Asynchronous reset in the middle of a start bit
        bus_write(8'h88, 8'h00);
        repeat (5) @(posedge clk);
        #1 check("tx_start_low", {7'b0, tx}, 8'h00);
        #2 reset_n = 1'b0;
        #1 check("tx_async_rst", {7'b0, tx}, 8'h01);
        @(negedge clk);
        reset_n = 1'b1;
        read_check("ctrl_after_rst",   8'h8A, 8'h00);
        read_check("status_after_rst", 8'h89, 8'h06);
        read_check("div_after_rst",    8'h8B, 8'h35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
